tff_ctrl: RTL and testbench
===========================

Name: tff_ctrl

Overview:
Synchronous controller for one tff temporal-memory cell. It is the digital end of the cell's delay-coded interface.
- Write: converts a binary value into a WE pulse whose length in clocks equals the value.
- Read: asserts RE and times the cell's `out` rising edge, converting the stored delay back to binary.
- Sits between a valid/ready command interface and the cell's WE/RE/rstb/out/carry pins.

Parameters:
- DATA_W, 4, width of stored value; max encodable delay 2**DATA_W-1 clocks.
- CLR_CYC, 2, clocks rstb is held low when clearing before a write.
- SYNC_STAGES, 2, flops in the out/carry synchronizers; subtracted from measured read time.
- TIMEOUT, 2**DATA_W+SYNC_STAGES+2, read cycles before overflow is declared.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, command accepted when valid&ready
- cmd_wr  in  1  1=write, 0=read
- cmd_data  in  DATA_W  write value
- rsp_valid  out  1  one-clock pulse, read result present
- rsp_data  out  DATA_W  read value
- rsp_ovf  out  1  read timed out or carry seen; qualified by rsp_valid
- tff_we  out  1  to cell WE
- tff_re  out  1  to cell RE
- tff_rstb  out  1  to cell rstb (active low)
- tff_out  in  1  from cell out (asynchronous)
- tff_carry  in  1  from cell carry (asynchronous)

Behaviour:
Reset (rst=1 at posedge clk):
- state=IDLE, cmd_ready=0 during reset then 1 the cycle after.
- tff_we=0, tff_re=0, tff_rstb=0 (cell held cleared).
- rsp_valid=0, rsp_data=0, rsp_ovf=0, counter=0, synchronizers cleared.
- rst mid-operation aborts immediately; no rsp_valid is emitted for the aborted command.

General:
- All outputs are registered.
- tff_out and tff_carry pass through SYNC_STAGES-flop synchronizers; only synchronized versions are used.
- cmd_ready=1 only in IDLE. In IDLE: tff_rstb=1, tff_we=0, tff_re=0.

States and transitions:
- IDLE: on cmd_valid, latch cmd_wr and cmd_data, clear counter.
  - write → CLEAR
  - read → READ
- CLEAR: tff_rstb=0 for exactly CLR_CYC clocks, then tff_rstb=1 and →
  - WRITE if data≠0
  - IDLE if data=0 (cell left cleared, no WE pulse)
- WRITE: tff_we=1 for exactly data clocks, counted from its first high cycle. Then tff_we=0 → IDLE. No rsp for writes.
- READ: tff_re=1, counter increments every clock.
  - First clock where synced out rises (0→1 edge): rsp_data = counter−SYNC_STAGES, saturated at 0 and at 2**DATA_W−1; rsp_ovf = synced carry. → DONE.
  - counter reaches TIMEOUT: rsp_data = all ones, rsp_ovf=1. → DONE.
- DONE: tff_re=0, rsp_valid=1 for one clock → IDLE.

Boundary and edge rules:
- If synced out is already 1 on READ entry, only a true rising edge ends the read; otherwise the read ends by TIMEOUT.
- cmd_valid while busy is ignored (held by requester).
- cmd_valid in the same cycle rst deasserts is not accepted, because cmd_ready=0 then.
- Counter width: clog2(TIMEOUT+1); it never wraps.
- Back-to-back commands: the next command can be accepted the clock after the return to IDLE, i.e. one idle cycle minimum.

Decomposition:
- Package tff_ctrl_pkg:
  - state enum {IDLE, CLEAR, WRITE, READ, DONE}
  - cmd opcode constants CMD_RD=0, CMD_WR=1
  - counter-width function
- One sub-module, tff_sync: a SYNC_STAGES-deep synchronizer with synchronous reset. Instantiated twice, for out and carry.

Test Plan:
- Reset, then idle → tff_rstb=1, tff_we=0, tff_re=0, cmd_ready=1, rsp_valid=0.
- Write cmd_data=5 → tff_rstb low exactly 2 clocks, then tff_we high exactly 5 clocks; cmd_ready back after 8 clocks.
- Write 0 → 2-clock rstb low, no tff_we pulse.
- Read with behavioural cell model whose out rises 7 clocks after tff_re → rsp_valid once, rsp_data=7, rsp_ovf=0, then tff_re=0.
- Read with out held 0 → after TIMEOUT=20 clocks, rsp_data=15, rsp_ovf=1.
- Read with model raising carry before out; also rst asserted mid-WRITE:
  - carry case → rsp_ovf=1 with the measured rsp_data.
  - mid-WRITE rst → tff_we drops next clock, tff_rstb=0, no rsp_valid.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// rtl/tff_ctrl_pkg.sv - shared types and helpers for the tff cell controller
package tff_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } tff_state_e;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Counter must hold TIMEOUT itself without wrapping.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/tff_sync.sv
// rtl/tff_sync.sv - multi-flop synchronizer with synchronous reset
module tff_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tff_ctrl.sv
// rtl/tff_ctrl.sv - delay-coded write/read controller for one tff cell
module tff_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int CLR_CYC     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**DATA_W + SYNC_STAGES + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf,
    output logic              tff_we,
    output logic              tff_re,
    output logic              tff_rstb,
    input  logic              tff_out,
    input  logic              tff_carry
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CLR_C     = CNT_W'(CLR_CYC);
    localparam logic [CNT_W-1:0] SYNC_C    = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(2**DATA_W - 1);

    tff_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              rstb_q, rstb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic              out_prev_q;

    logic              out_s;
    logic              carry_s;
    logic              out_rise;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  meas;

    tff_sync #(.STAGES(SYNC_STAGES)) u_sync_out (
        .clk (clk),
        .rst (rst),
        .d_i (tff_out),
        .q_o (out_s)
    );

    tff_sync #(.STAGES(SYNC_STAGES)) u_sync_carry (
        .clk (clk),
        .rst (rst),
        .d_i (tff_carry),
        .q_o (carry_s)
    );

    assign out_rise = out_s & ~out_prev_q;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Remove synchronizer latency from the measured delay, clamping at zero.
    always_comb begin
        meas = '0;
        if (cnt_q >= SYNC_C) begin
            meas = cnt_q - SYNC_C;
        end
    end

    // Next-state and registered-output logic for the command sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        cmd_ready_d = 1'b0;
        we_d        = 1'b0;
        re_d        = 1'b0;
        rstb_d      = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    data_d      = cmd_data;
                    cnt_d       = '0;
                    if (cmd_wr == CMD_WR) begin
                        state_d = CLEAR;
                        rstb_d  = 1'b0;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                    end
                end
            end
            CLEAR: begin
                rstb_d = 1'b0;
                cnt_d  = cnt_inc;
                if (cnt_inc == CLR_C) begin
                    rstb_d = 1'b1;
                    cnt_d  = '0;
                    if (data_q != '0) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                we_d  = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(data_q)) begin
                    we_d        = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            READ: begin
                re_d = 1'b1;
                if (cnt_q != TIMEOUT_C) begin
                    cnt_d = cnt_inc;
                end
                // A real edge wins over a timeout landing in the same cycle.
                if (out_rise) begin
                    state_d     = DONE;
                    re_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_ovf_d   = carry_s;
                    rsp_data_d  = (meas > MAX_C) ? '1 : meas[DATA_W-1:0];
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d     = DONE;
                    re_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_ovf_d   = 1'b1;
                    rsp_data_d  = '1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves the cell held cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            cmd_ready_q <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rstb_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            out_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            cmd_ready_q <= cmd_ready_d;
            we_q        <= we_d;
            re_q        <= re_d;
            rstb_q      <= rstb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            out_prev_q  <= out_s;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign tff_we    = we_q;
    assign tff_re    = re_q;
    assign tff_rstb  = rstb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_tff_ctrl.sv
// tb/tb_tff_ctrl.sv - directed self-checking bench for tff_ctrl
module tb_tff_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_ovf;
    logic       tff_we;
    logic       tff_re;
    logic       tff_rstb;
    logic       tff_out;
    logic       tff_carry;

    int checks;
    int errors;

    tff_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .tff_we    (tff_we),
        .tff_re    (tff_re),
        .tff_rstb  (tff_rstb),
        .tff_out   (tff_out),
        .tff_carry (tff_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for cmd_ready, then presents one command for one edge.
    task automatic issue_cmd(input logic wr, input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_ready got=%0b want=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_data  = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Read with a cell model: out/carry rise the given clocks after tff_re.
    task automatic run_read(input int out_at, input int carry_at, input int maxk,
                            output int valid_k, output int valid_n, output int re_n,
                            output logic [3:0] d, output logic o);
        valid_k = -1;
        valid_n = 0;
        re_n    = 0;
        d       = 4'd0;
        o       = 1'b0;
        issue_cmd(1'b0, 4'd0);
        for (int k = 1; k <= maxk; k++) begin
            @(negedge clk);
            if (k == out_at + 1)   tff_out   = 1'b1;
            if (k == carry_at + 1) tff_carry = 1'b1;
            if (tff_re) re_n++;
            if (rsp_valid) begin
                valid_n++;
                if (valid_k < 0) begin
                    valid_k = k;
                    d       = rsp_data;
                    o       = rsp_ovf;
                end
            end
        end
        tff_out   = 1'b0;
        tff_carry = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b want=0", cmd_ready); end
        checks++; if (tff_rstb !== 1'b0) begin errors++; $display("FAIL rst_rstb got=%0b want=0", tff_rstb); end
        checks++; if (tff_we !== 1'b0 || tff_re !== 1'b0) begin errors++; $display("FAIL rst_we_re got=%0b%0b want=00", tff_we, tff_re); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 4'd0 || rsp_ovf !== 1'b0) begin errors++; $display("FAIL rst_rsp got=%0b/%0d/%0b want=0/0/0", rsp_valid, rsp_data, rsp_ovf); end
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_data  = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%0b want=1", cmd_ready); end
        checks++; if (tff_rstb !== 1'b1) begin errors++; $display("FAIL idle_rstb_no_accept got=%0b want=1", tff_rstb); end
        checks++; if (tff_we !== 1'b0 || tff_re !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_outs got=%0b%0b%0b want=000", tff_we, tff_re, rsp_valid); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write(input logic [3:0] val);
        int rl, wn, first_we, ready_k;
        rl = 0; wn = 0; first_we = -1; ready_k = -1;
        issue_cmd(1'b1, val);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!tff_rstb) rl++;
            if (tff_we) begin
                wn++;
                if (first_we < 0) first_we = k;
            end
            if (cmd_ready && ready_k < 0) ready_k = k;
        end
        checks++; if (rl !== 2) begin errors++; $display("FAIL wr%0d_rstb_low got=%0d want=2", val, rl); end
        checks++; if (wn !== int'(val)) begin errors++; $display("FAIL wr%0d_we_len got=%0d want=%0d", val, wn, val); end
        if (val != 4'd0) begin
            checks++; if (first_we !== 3) begin errors++; $display("FAIL wr%0d_we_start got=%0d want=3", val, first_we); end
        end
        checks++; if (ready_k !== 3 + int'(val)) begin errors++; $display("FAIL wr%0d_ready_back got=%0d want=%0d", val, ready_k, 3 + int'(val)); end
    endtask

    task automatic test_read_basic;
        int vk, vn, rn;
        logic [3:0] d;
        logic o;
        run_read(7, -1, 30, vk, vn, rn, d, o);
        checks++; if (vk !== 11 || vn !== 1) begin errors++; $display("FAIL rd7_valid got=k%0d n%0d want=k11 n1", vk, vn); end
        checks++; if (d !== 4'd7 || o !== 1'b0) begin errors++; $display("FAIL rd7_data got=%0d/%0b want=7/0", d, o); end
        checks++; if (rn !== 10) begin errors++; $display("FAIL rd7_re_len got=%0d want=10", rn); end
        run_read(0, -1, 30, vk, vn, rn, d, o);
        checks++; if (vk !== 4 || d !== 4'd0 || o !== 1'b0) begin errors++; $display("FAIL rd0 got=k%0d %0d/%0b want=k4 0/0", vk, d, o); end
    endtask

    task automatic test_timeout;
        int vk, vn, rn;
        logic [3:0] d;
        logic o;
        run_read(-1, -1, 30, vk, vn, rn, d, o);
        checks++; if (vk !== 21 || vn !== 1) begin errors++; $display("FAIL tmo_valid got=k%0d n%0d want=k21 n1", vk, vn); end
        checks++; if (d !== 4'd15 || o !== 1'b1) begin errors++; $display("FAIL tmo_data got=%0d/%0b want=15/1", d, o); end
        checks++; if (rn !== 20) begin errors++; $display("FAIL tmo_re_len got=%0d want=20", rn); end
        // Edge and timeout in the same cycle: the edge wins, value saturates.
        run_read(17, -1, 30, vk, vn, rn, d, o);
        checks++; if (vk !== 21 || d !== 4'd15 || o !== 1'b0) begin errors++; $display("FAIL sat_hi got=k%0d %0d/%0b want=k21 15/0", vk, d, o); end
        // Out already high on entry: no edge, so only the timeout ends it.
        tff_out = 1'b1;
        repeat (4) @(negedge clk);
        run_read(-1, -1, 30, vk, vn, rn, d, o);
        checks++; if (vk !== 21 || d !== 4'd15 || o !== 1'b1) begin errors++; $display("FAIL pre_high got=k%0d %0d/%0b want=k21 15/1", vk, d, o); end
    endtask

    task automatic test_carry;
        int vk, vn, rn;
        logic [3:0] d;
        logic o;
        run_read(5, 3, 30, vk, vn, rn, d, o);
        checks++; if (vk !== 9 || d !== 4'd5 || o !== 1'b1) begin errors++; $display("FAIL carry got=k%0d %0d/%0b want=k9 5/1", vk, d, o); end
    endtask

    task automatic test_back_to_back;
        int rk;
        rk = -1;
        issue_cmd(1'b1, 4'd2);
        for (int k = 1; k <= 10 && rk < 0; k++) begin
            @(negedge clk);
            if (cmd_ready) rk = k;
        end
        checks++; if (rk !== 5) begin errors++; $display("FAIL b2b_ready got=%0d want=5", rk); end
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (tff_re !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got=re%0b rdy%0b want=re1 rdy0", tff_re, cmd_ready); end
        for (int k = 0; k < 30; k++) @(negedge clk);
    endtask

    task automatic test_rst_mid_write;
        int vn, wn;
        vn = 0; wn = 0;
        issue_cmd(1'b1, 4'd9);
        repeat (5) @(negedge clk);
        checks++; if (tff_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we got=%0b want=1", tff_we); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tff_we !== 1'b0 || tff_rstb !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL midrst_abort got=we%0b rstb%0b rdy%0b want=we0 rstb0 rdy0", tff_we, tff_rstb, cmd_ready); end
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (rsp_valid) vn++;
            if (tff_we) wn++;
        end
        checks++; if (vn !== 0 || wn !== 0) begin errors++; $display("FAIL midrst_quiet got=valid%0d we%0d want=0 0", vn, wn); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%0b want=1", cmd_ready); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_data  = 4'd0;
        tff_out   = 1'b0;
        tff_carry = 1'b0;
        test_reset();
        test_write(4'd5);
        test_write(4'd0);
        test_read_basic();
        test_timeout();
        test_carry();
        test_back_to_back();
        test_rst_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
